// File: rtl/mips_div_pkg.sv
// Shared types and constants for the MIPS multi-cycle divide unit.
package mips_div_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FIXUP = 2'd2
   } div_state_e;

   localparam int          DIV_ITERS   = 32;
   localparam logic [4:0]  DIV_OP      = 5'b01010;
   localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

   function automatic logic is_div_op(input logic [4:0] aluop);
      return aluop == DIV_OP;
   endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Pipeline-side bundle for the divide unit: issue, HI/LO read and status.
interface div_sequencer_if #(
   parameter int WIDTH = 32
) ();

   logic             div_start;
   logic             div_signed;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic             hilo_read;
   logic             hilo_sel;
   logic [WIDTH-1:0] hilo_data;
   logic             busy;
   logic             stall;
   logic             done;
   logic             div_by_zero;

   modport master (
      output div_start, div_signed, rs_val, rt_val, hilo_read, hilo_sel,
      input  hilo_data, busy, stall, done, div_by_zero
   );

   modport slave (
      input  div_start, div_signed, rs_val, rt_val, hilo_read, hilo_sel,
      output hilo_data, busy, stall, done, div_by_zero
   );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract divisor.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] rem_sh;
   logic           fits;

   always_comb begin
      rem_sh = {rem_i, quo_i[WIDTH-1]};
      fits   = rem_sh >= {1'b0, divisor_i};
      // A fitting difference is always below the divisor, so it fits WIDTH bits.
      if (fits) begin
         rem_o = WIDTH'(rem_sh - {1'b0, divisor_i});
         quo_o = {quo_i[WIDTH-2:0], 1'b1};
      end else begin
         rem_o = rem_sh[WIDTH-1:0];
         quo_o = {quo_i[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_sequencer.sv
// DIV/DIVU sequencer: magnitude restoring divider, sign fixup, HI/LO and stall.
module div_sequencer
   import mips_div_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITERS = WIDTH
) (
   input  logic          clk,
   input  logic          reset,
   div_sequencer_if.slave bus
);

   localparam int                CNT_W     = $clog2(ITERS);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITERS - 1);

   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
      return (~v) + WIDTH'(1);
   endfunction

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                   input logic neg);
      return neg ? negate(v) : v;
   endfunction

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic [WIDTH-1:0] dividend_q, dividend_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             zero_q, zero_d;

   logic signed [WIDTH-1:0] rs_s;
   logic signed [WIDTH-1:0] rt_s;
   logic                    rs_neg;
   logic                    rt_neg;
   logic [WIDTH-1:0]        step_rem;
   logic [WIDTH-1:0]        step_quo;
   logic                    busy;

   assign rs_s   = bus.rs_val;
   assign rt_s   = bus.rt_val;
   assign rs_neg = bus.div_signed && (rs_s < 0);
   assign rt_neg = bus.div_signed && (rt_s < 0);

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (dvsr_q),
      .rem_o     (step_rem),
      .quo_o     (step_quo)
   );

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      dbz_d      = 1'b0;
      rem_d      = rem_q;
      quo_d      = quo_q;
      dvsr_d     = dvsr_q;
      dividend_d = dividend_q;
      qneg_d     = qneg_q;
      rneg_d     = rneg_q;
      zero_d     = zero_q;

      unique case (state_q)
         IDLE: begin
            if (bus.div_start) begin
               dividend_d = bus.rs_val;
               dvsr_d     = apply_sign(bus.rt_val, rt_neg);
               quo_d      = apply_sign(bus.rs_val, rs_neg);
               rem_d      = '0;
               qneg_d     = rs_neg ^ rt_neg;
               rneg_d     = rs_neg;
               zero_d     = (bus.rt_val == '0);
               count_d    = '0;
               state_d    = RUN;
            end
         end
         RUN: begin
            rem_d   = step_rem;
            quo_d   = step_quo;
            count_d = count_q + CNT_W'(1);
            if (count_q == LAST_STEP) state_d = FIXUP;
         end
         FIXUP: begin
            // A zero divisor still takes the full latency; the result is fixed.
            if (zero_q) begin
               lo_d  = '1;
               hi_d  = dividend_q;
               dbz_d = 1'b1;
            end else begin
               lo_d = apply_sign(quo_q, qneg_q);
               hi_d = apply_sign(rem_q, rneg_q);
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   always_ff @(posedge clk) begin
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      dividend_q <= dividend_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      zero_q     <= zero_d;
   end

   assign busy            = (state_q != IDLE);
   assign bus.busy        = busy;
   assign bus.stall       = busy & (bus.div_start | bus.hilo_read);
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.hilo_data   = bus.hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a cycle-level reference model.
module tb_div_sequencer;
   import mips_div_pkg::*;

   logic clk;
   logic reset;
   bit   chk_en;
   int   n_checks;
   int   n_fail;

   div_sequencer_if #(.WIDTH(32)) bus ();

   div_sequencer #(.WIDTH(32), .ITERS(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: results from plain magnitude arithmetic, timing as a busy countdown.
   function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [31:0] ma, mb, uq, ur, q, r;
      if (b == 32'd0) return {a, DIV_ZERO_LO};
      ma = (sgn && a[31]) ? (32'd0 - a) : a;
      mb = (sgn && b[31]) ? (32'd0 - b) : b;
      uq = ma / mb;
      ur = ma % mb;
      q  = (sgn && (a[31] ^ b[31])) ? (32'd0 - uq) : uq;
      r  = (sgn && a[31]) ? (32'd0 - ur) : ur;
      return {r, q};
   endfunction

   int          m_cnt;
   logic [31:0] m_hi, m_lo;
   logic [63:0] m_pend;
   logic        m_zero, m_done, m_dbz;

   always @(posedge clk) begin
      if (reset) begin
         m_cnt  <= 0;
         m_hi   <= '0;
         m_lo   <= '0;
         m_done <= 1'b0;
         m_dbz  <= 1'b0;
      end else if (m_cnt != 0) begin
         m_cnt  <= m_cnt - 1;
         m_done <= (m_cnt == 1);
         m_dbz  <= (m_cnt == 1) && m_zero;
         if (m_cnt == 1) {m_hi, m_lo} <= m_pend;
      end else begin
         m_done <= 1'b0;
         m_dbz  <= 1'b0;
         if (bus.div_start) begin
            m_cnt  <= 33;
            m_pend <= ref_div(bus.div_signed, bus.rs_val, bus.rt_val);
            m_zero <= (bus.rt_val == 32'd0);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_busy",  32'(bus.busy), 32'(m_cnt != 0));
         check("model_stall", 32'(bus.stall),
               32'((m_cnt != 0) && (bus.div_start || bus.hilo_read)));
         check("model_done",  32'(bus.done), 32'(m_done));
         check("model_dbz",   32'(bus.div_by_zero), 32'(m_dbz));
         check("model_hilo",  bus.hilo_data, bus.hilo_sel ? m_hi : m_lo);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic start_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      bus.div_start  = 1'b1;
      bus.div_signed = sgn;
      bus.rs_val     = a;
      bus.rt_val     = b;
      tick();
      bus.div_start  = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int busy_n);
      lat    = 1;
      busy_n = 0;
      while (!bus.done && lat < 60) begin
         if (bus.busy) busy_n++;
         tick();
         lat++;
      end
   endtask

   task automatic check_result(input string tag, input logic [31:0] elo,
                               input logic [31:0] ehi, input logic edbz);
      check({tag, "_done"}, 32'(bus.done), 32'd1);
      check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(edbz));
      bus.hilo_sel = 1'b0;
      #1 check({tag, "_lo"}, bus.hilo_data, elo);
      bus.hilo_sel = 1'b1;
      #1 check({tag, "_hi"}, bus.hilo_data, ehi);
      bus.hilo_sel = 1'b0;
   endtask

   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] elo,
                          input logic [31:0] ehi, input logic edbz);
      int lat, busy_n;
      start_div(sgn, a, b);
      wait_done(lat, busy_n);
      check({tag, "_latency"}, 32'(lat), 32'd34);
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'd33);
      check_result(tag, elo, ehi, edbz);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected end by 100000");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, lat, busy_n, dones;
      n_checks       = 0;
      n_fail         = 0;
      chk_en         = 1'b0;
      reset          = 1'b1;
      bus.div_start  = 1'b0;
      bus.div_signed = 1'b0;
      bus.rs_val     = '0;
      bus.rt_val     = '0;
      bus.hilo_read  = 1'b0;
      bus.hilo_sel   = 1'b0;
      tick();
      chk_en = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("rst_busy",  32'(bus.busy), 32'd0);
      check("rst_stall", 32'(bus.stall), 32'd0);
      check("rst_done",  32'(bus.done), 32'd0);
      check("rst_dbz",   32'(bus.div_by_zero), 32'd0);
      check("rst_lo",    bus.hilo_data, 32'd0);
      bus.hilo_sel = 1'b1;
      #1 check("rst_hi", bus.hilo_data, 32'd0);
      bus.hilo_sel = 1'b0;
      tick();

      run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
      run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
      run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
      run_div("divu_zero", 1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1);
      tick();

      // MFLO five cycles into a divide is held until the result lands.
      start_div(1'b0, 32'd1000, 32'd10);
      repeat (5) tick();
      bus.hilo_read = 1'b1;
      bus.hilo_sel  = 1'b0;
      #1;
      n = 0;
      while (bus.stall && n < 60) begin
         tick();
         n++;
      end
      check("read_stall_cycles", 32'(n), 32'd28);
      check("read_done", 32'(bus.done), 32'd1);
      check("read_lo", bus.hilo_data, 32'd100);
      bus.hilo_read = 1'b0;
      tick();

      // A second divide issued mid-flight waits and starts in the done cycle.
      start_div(1'b0, 32'd50, 32'd5);
      repeat (2) tick();
      bus.div_start  = 1'b1;
      bus.div_signed = 1'b0;
      bus.rs_val     = 32'd81;
      bus.rt_val     = 32'd9;
      #1;
      n = 0;
      while (bus.stall && n < 60) begin
         tick();
         n++;
      end
      check("b2b_stall_cycles", 32'(n), 32'd31);
      check_result("b2b_first", 32'd10, 32'd0, 1'b0);
      tick();
      bus.div_start = 1'b0;
      wait_done(lat, busy_n);
      check("b2b_latency", 32'(lat), 32'd34);
      check_result("b2b_second", 32'd9, 32'd0, 1'b0);
      tick();

      // Reset ten cycles into RUN aborts the divide and clears HI/LO.
      start_div(1'b0, 32'd500, 32'd3);
      repeat (9) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_lo", bus.hilo_data, 32'd0);
      bus.hilo_sel = 1'b1;
      #1 check("abort_hi", bus.hilo_data, 32'd0);
      bus.hilo_sel = 1'b0;
      dones = 0;
      repeat (40) begin
         tick();
         if (bus.done) dones++;
      end
      check("abort_no_done", 32'(dones), 32'd0);

      reset         = 1'b1;
      bus.div_start = 1'b1;
      bus.rs_val    = 32'd77;
      bus.rt_val    = 32'd7;
      tick();
      reset         = 1'b0;
      bus.div_start = 1'b0;
      #1 check("reset_over_start_busy", 32'(bus.busy), 32'd0);
      tick();

      run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

      // Read and start together in IDLE: old LO is returned, divide starts.
      bus.div_start  = 1'b1;
      bus.div_signed = 1'b1;
      bus.rs_val     = 32'hFFFF_FF9C;
      bus.rt_val     = 32'd7;
      bus.hilo_read  = 1'b1;
      bus.hilo_sel   = 1'b0;
      #1;
      check("idle_rd_stall", 32'(bus.stall), 32'd0);
      check("idle_rd_lo", bus.hilo_data, 32'd3);
      tick();
      bus.div_start = 1'b0;
      bus.hilo_read = 1'b0;
      wait_done(lat, busy_n);
      check("div_m100_7_latency", 32'(lat), 32'd34);
      check_result("div_m100_7", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
